mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Arbitrates the CPU's single memory port between the instruction-fetch requester (PC -> MAR -> IR path) and the data requester (LD/ST/LDR/STR execute path).
- Sits between the control unit and the memory interface and owns the MAR/MDR/rw/ena sequencing.
- Data accesses have priority; a starvation counter guarantees fetch progress.
- Supports variable memory wait states through a ready handshake.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
MAX_STARVE, 4, consecutive data grants allowed while fetch is pending before fetch is forced
TIMEOUT, 64, cycles in ACCESS before abort (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held high until if_ack
if_addr  in  ADDR_W  fetch address (PC)
if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid
if_rdata  out  DATA_W  fetched instruction word
d_req  in  1  data request; held high until d_ack
d_addr  in  ADDR_W  data address
d_rw  in  1  0 = read, 1 = write (matches codebase R = 0)
d_byte  in  1  1 = byte access, 0 = word access
d_wdata  in  DATA_W  write data; byte data in [7:0]
d_ack  out  1  one-cycle pulse: data access complete
d_rdata  out  DATA_W  read data; byte reads zero-extended
mem_ena  out  1  memory access enable
mem_rw  out  1  memory direction, 0 = read
mem_addr  out  ADDR_W  memory address (MAR)
mem_be  out  2  byte enables [1] = high byte, [0] = low byte
mem_wdata  out  DATA_W  memory write data (MDR out)
mem_rdata  in  DATA_W  memory read data (MDR in)
mem_ready  in  1  memory completes the access this cycle
busy  out  1  high whenever state is not IDLE
bus_fault  out  1  one-cycle pulse on timeout abort (optional feature)

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state = IDLE; mem_ena, mem_rw, if_ack, d_ack, busy, bus_fault = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; mem_be = 2'b00; starve counter = 0.
- Reset mid-access: the access is abandoned immediately, mem_ena drops asynchronously, and no ack is issued.
- FSM states:
  - IDLE: requests are sampled only in this state.
  - ACCESS: mem_ena = 1. mem_addr, mem_rw, mem_be and mem_wdata are registered at grant and held stable until exit.
  - RESP: exactly one ack is high for one cycle; the rdata output is valid that cycle and holds until the next grant.
- Transitions:
  - IDLE -> ACCESS when either request is high.
  - ACCESS -> RESP on the edge where mem_ready = 1; mem_rdata is captured on that edge.
  - RESP -> IDLE unconditionally.
- Minimum latency: request high in cycle 0 -> mem_ena in cycle 1 -> mem_ready in cycle 1 -> ack in cycle 2. Each wait state adds one cycle.
- Back-to-back accesses: a requester may drop req, or present a new request, on the edge at which it sees ack. In the following IDLE cycle, req reflects the new request. Peak throughput is one access per 3 cycles.
- Arbitration:
  - d_req wins over if_req by default.
  - Starve counter: increments on each data grant while if_req = 1, saturating at MAX_STARVE; clears on any fetch grant.
  - When the counter equals MAX_STARVE and if_req = 1, the fetch is granted even if d_req = 1.
  - A simultaneous d_req and if_req with counter < MAX_STARVE grants data.
- Fetch is always a word read: mem_rw = 0, mem_be = 2'b11, mem_addr = if_addr with bit 0 cleared.
- Data word access: mem_be = 2'b11; bit 0 of the address is cleared.
- Data byte access:
  - mem_be = 2'b01 if d_addr[0] = 0, else 2'b10.
  - Byte write: d_wdata[7:0] is replicated onto both halves of mem_wdata.
  - Byte read: d_rdata = zero-extended selected byte.
- mem_rdata is ignored for writes; d_rdata holds its previous value after a write.
- Requests deasserted while the arbiter is in ACCESS are protocol violations; the access completes regardless and the ack is still issued.

Optional Feature:
BUS_TIMEOUT_EN
- Defined:
  - An ACCESS cycle counter runs from grant.
  - If mem_ready has not been seen after TIMEOUT cycles, the FSM goes to RESP with the granted requester's ack high, its rdata forced to all-ones, and bus_fault = 1 for that cycle.
  - mem_ena deasserts on the abort edge.
  - The counter resets on every grant.
- Undefined: the arbiter waits indefinitely for mem_ready, bus_fault is tied 0, and no counter logic is present.

Test Plan:
1. Reset, then if_req = 1, if_addr = 0x0101, mem_ready tied 1 -> mem_addr = 0x0100, mem_be = 11, mem_rw = 0 in cycle 1; if_ack pulse in cycle 2 with if_rdata = mem_rdata (0xABCD).
2. d_req = 1, d_rw = 1, d_byte = 1, d_addr = 0x2003, d_wdata = 0x0055, 2 wait states -> mem_be = 10, mem_wdata = 0x5555, mem_ena high 3 cycles, d_ack 1 cycle after mem_ready.
3. d_req and if_req both held high continuously, MAX_STARVE = 4 -> grant order D, D, D, D, F, D, D, D, D, F; each ack is 1 cycle; both acks never high together.
4. Byte read at d_addr = 0x0011 with mem_rdata = 0x12F0 -> d_rdata = 0x0012; a word read at 0x0010 -> 0x12F0.
5. rst_n pulsed low while in ACCESS with 5 wait states -> mem_ena = 0 immediately; no ack; busy = 0; next request is serviced normally.
6. With BUS_TIMEOUT_EN, TIMEOUT = 8, mem_ready held 0 -> after 8 ACCESS cycles, d_ack = 1, d_rdata = 0xFFFF, bus_fault = 1 for one cycle; FSM returns to IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of requester-side and memory-side signals for mem_bus_arbiter.
// slave = arbiter view, master = requesters plus memory view.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_rw;
    logic              d_byte;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_ena;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              busy;
    logic              bus_fault;

    modport slave (
        input  if_req, if_addr, d_req, d_addr, d_rw, d_byte, d_wdata,
        input  mem_rdata, mem_ready,
        output if_ack, if_rdata, d_ack, d_rdata,
        output mem_ena, mem_rw, mem_addr, mem_be, mem_wdata,
        output busy, bus_fault
    );

    modport master (
        output if_req, if_addr, d_req, d_addr, d_rw, d_byte, d_wdata,
        output mem_rdata, mem_ready,
        input  if_ack, if_rdata, d_ack, d_rdata,
        input  mem_ena, mem_rw, mem_addr, mem_be, mem_wdata,
        input  busy, bus_fault
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Single-port memory arbiter: data accesses win, a starve counter forces fetch progress.
// Optional BUS_TIMEOUT_EN adds an ACCESS watchdog that aborts with bus_fault.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MAX_STARVE = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_bus_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int               SW            = $clog2(MAX_STARVE + 1);
    localparam logic [SW-1:0]    LP_MAX_STARVE = SW'(MAX_STARVE);
    localparam logic [ADDR_W-1:0] LP_WORD_MASK = ~ADDR_W'(1);

    state_t            r_state;
    logic [SW-1:0]     r_starve;
    logic              r_gnt_d;
    logic              r_d_byte;
    logic              r_d_lane;
    logic              r_mem_ena;
    logic              r_mem_rw;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [1:0]        r_mem_be;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_if_ack;
    logic              r_d_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_busy;

    logic              w_fetch_force;
    logic              w_gnt_fetch;
    logic              w_gnt_data;
    logic [SW-1:0]     w_starve_inc;
    logic [1:0]        w_byte_be;
    logic [DATA_W-1:0] w_byte_wdata;
    logic [DATA_W-1:0] w_byte_rdata;
    logic [DATA_W-1:0] w_d_rdata_next;
    logic              w_abort;

    // Fetch is forced only once data has been granted MAX_STARVE times in a row over it.
    assign w_fetch_force = bus.if_req && (r_starve == LP_MAX_STARVE);
    assign w_gnt_fetch   = bus.if_req && (!bus.d_req || w_fetch_force);
    assign w_gnt_data    = bus.d_req && !w_gnt_fetch;
    assign w_starve_inc  = (r_starve == LP_MAX_STARVE) ? r_starve : r_starve + SW'(1);

    assign w_byte_be      = bus.d_addr[0] ? 2'b10 : 2'b01;
    assign w_byte_wdata   = {(DATA_W/8){bus.d_wdata[7:0]}};
    assign w_byte_rdata   = r_d_lane ? {{(DATA_W-8){1'b0}}, bus.mem_rdata[15:8]}
                                     : {{(DATA_W-8){1'b0}}, bus.mem_rdata[7:0]};
    assign w_d_rdata_next = r_d_byte ? w_byte_rdata : bus.mem_rdata;

`ifdef BUS_TIMEOUT_EN
    localparam int            TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LP_TO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_to_cnt;
    logic          r_bus_fault;

    assign w_abort       = !bus.mem_ready && (r_to_cnt == LP_TO_LAST);
    assign bus.bus_fault = r_bus_fault;
`else
    assign w_abort       = 1'b0;
    // No watchdog in this build, so no fault source exists.
    assign bus.bus_fault = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_starve    <= '0;
            r_gnt_d     <= 1'b0;
            r_d_byte    <= 1'b0;
            r_d_lane    <= 1'b0;
            r_mem_ena   <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 2'b00;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_d_ack     <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_busy      <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_bus_fault <= 1'b0;
`endif
        end else begin
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            r_bus_fault <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_fetch || w_gnt_data) begin
                        r_state   <= ST_ACCESS;
                        r_busy    <= 1'b1;
                        r_mem_ena <= 1'b1;
                        r_gnt_d   <= w_gnt_data;
`ifdef BUS_TIMEOUT_EN
                        r_to_cnt  <= '0;
`endif
                        if (w_gnt_fetch) begin
                            r_starve   <= '0;
                            r_mem_rw   <= 1'b0;
                            r_mem_addr <= bus.if_addr & LP_WORD_MASK;
                            r_mem_be   <= 2'b11;
                        end else begin
                            if (bus.if_req) begin
                                r_starve <= w_starve_inc;
                            end
                            r_mem_rw <= bus.d_rw;
                            r_d_byte <= bus.d_byte;
                            r_d_lane <= bus.d_addr[0];
                            if (bus.d_byte) begin
                                r_mem_addr  <= bus.d_addr;
                                r_mem_be    <= w_byte_be;
                                r_mem_wdata <= w_byte_wdata;
                            end else begin
                                r_mem_addr  <= bus.d_addr & LP_WORD_MASK;
                                r_mem_be    <= 2'b11;
                                r_mem_wdata <= bus.d_wdata;
                            end
                        end
                    end
                end

                ST_ACCESS: begin
                    if (bus.mem_ready || w_abort) begin
                        r_state   <= ST_RESP;
                        r_mem_ena <= 1'b0;
`ifdef BUS_TIMEOUT_EN
                        r_bus_fault <= w_abort;
`endif
                        // Writes leave the previous read data visible on d_rdata.
                        if (r_gnt_d) begin
                            r_d_ack <= 1'b1;
                            if (w_abort) begin
                                r_d_rdata <= '1;
                            end else if (!r_mem_rw) begin
                                r_d_rdata <= w_d_rdata_next;
                            end
                        end else begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= w_abort ? '1 : bus.mem_rdata;
                        end
                    end else begin
`ifdef BUS_TIMEOUT_EN
                        r_to_cnt <= r_to_cnt + TW'(1);
`endif
                    end
                end

                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_mem_ena <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_ena   = r_mem_ena;
    assign bus.mem_rw    = r_mem_rw;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_ack    = r_if_ack;
    assign bus.d_ack     = r_d_ack;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.busy      = r_busy;

endmodule
